block_serial_skip_subtractor: RTL
=================================

Name: block_serial_skip_subtractor

Overview:
- Multi-cycle integer subtractor. Computes result = A - B - borrow_in over DATA_WIDTH/BLOCK_WIDTH cycles, one BLOCK_WIDTH slice per cycle, starting from the LSB slice.
- Each slice uses ripple-borrow logic. A borrow-skip mux bypasses the slice when every bit pair of A and B is equal.
- Serves as the subtraction counterpart of the team's carry-skip adder, for area-constrained datapaths (ALU back-ends, iterative dividers).
- Valid/ready input handshake; single-cycle valid pulse on output.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be an integer multiple of BLOCK_WIDTH.
- BLOCK_WIDTH, 4, bits processed per compute cycle; 1 <= BLOCK_WIDTH <= DATA_WIDTH.
- Derived localparam N_BLOCKS = DATA_WIDTH/BLOCK_WIDTH; block counter width = max(1, clog2(N_BLOCKS)).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- operand_A_i  input  DATA_WIDTH  minuend.
- operand_B_i  input  DATA_WIDTH  subtrahend.
- borrow_i  input  1  borrow in, subtracted at bit 0.
- valid_i  input  1  request strobe.
- ready_o  output  1  high when idle and able to accept.
- result_o  output  DATA_WIDTH  difference, registered.
- borrow_o  output  1  borrow out of the MSB: 1 when A < B + borrow_i (unsigned).
- overflow_o  output  1  two's-complement signed overflow.
- valid_o  output  1  one-cycle pulse; result/borrow/overflow are valid.

Behaviour:
- Reset (async, while rst_i=1) clears:
  - state to IDLE; result_o=0, borrow_o=0, overflow_o=0, valid_o=0, counter=0, internal operand/borrow registers=0.
  - ready_o=1 after reset. A handshake presented while rst_i=1 has no effect.
- States:
  - IDLE: ready_o=1. On valid_i & ready_o at a clock edge, latch A, B and borrow_i; clear counter; go to COMPUTE. Otherwise stay.
  - COMPUTE: ready_o=0. Each cycle processes slice k = counter:
    - per bit: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
    - slice borrow out = (&(~(a ^ b))) ? slice borrow in : ripple borrow out (skip mux).
    - Write d into result slice k; register the slice borrow as the next slice's borrow in; increment counter.
    - When counter == N_BLOCKS-1, go to DONE.
  - DONE: ready_o=0, valid_o=1 for exactly this cycle. borrow_o = final borrow; overflow_o = (A[MSB] != B[MSB]) & (result[MSB] != A[MSB]). Next state IDLE.
- Latency: accept at edge T. valid_o is high in the cycle after edge T+N_BLOCKS (N_BLOCKS COMPUTE cycles plus 1 DONE cycle). For 32/4: 9 cycles from accept to valid_o.
- Throughput: one operation per N_BLOCKS+2 cycles. The earliest next accept is the IDLE cycle following DONE.
- Output hold:
  - result_o, borrow_o and overflow_o keep their values after DONE until the next accepted request's DONE.
  - During COMPUTE, result_o may show partially updated slices. Consumers sample only on valid_o.
- Inputs are sampled only on accept. Changes to operand_A_i, operand_B_i or borrow_i during COMPUTE/DONE have no effect. valid_i while ready_o=0 is ignored, not queued.
- N_BLOCKS=1: a single COMPUTE cycle, then DONE.
- rst_i asserted in any state: immediate abort, outputs go to reset values, no valid_o for the aborted operation.
- Results are bit-exact with (A - B - borrow_in) mod 2^DATA_WIDTH for all operands.

Test Plan (DATA_WIDTH=32, BLOCK_WIDTH=4):
- A=0x00000005, B=0x00000003, borrow_i=0 -> result 0x00000002, borrow_o=0, overflow_o=0; valid_o 9 cycles after accept, for 1 cycle.
- A=0x00000000, B=0x00000001, borrow_i=0 -> result 0xFFFFFFFF, borrow_o=1, overflow_o=0 (blocks 1-7 take the skip path).
- A=0x80000000, B=0x00000001, borrow_i=0 -> result 0x7FFFFFFF, borrow_o=0, overflow_o=1.
- A=B=0x12345678, borrow_i=1 -> result 0xFFFFFFFF, borrow_o=1 (full skip chain). The same operands with borrow_i=0 -> 0x00000000, borrow_o=0.
- Accept A=9, B=4, then assert rst_i in the 4th COMPUTE cycle -> all outputs 0 immediately, ready_o=1 after release, no valid_o. A fresh request then completes correctly.
- Hold valid_i=1 continuously with new operands changed every cycle -> exactly one accept per 10 cycles. Each valid_o matches the operands present at its accept edge; ready_o=0 throughout COMPUTE/DONE.

Source files
------------

// File: rtl/block_serial_skip_subtractor.sv
// Block-serial subtractor: one BLOCK_WIDTH slice per cycle, LSB slice first.
// Each slice ripples its borrow internally. A skip mux passes the borrow straight through when A and B are equal across the slice.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | ready_o high, waiting for valid_i
// ST_COMPUTE| processing slice cnt_q, borrow chained via bin_q
// ST_DONE   | valid_o pulse, result/borrow/overflow final
module block_serial_skip_subtractor #(
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WIDTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] operand_A_i,
   input  logic [DATA_WIDTH-1:0] operand_B_i,
   input  logic                  borrow_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  borrow_o,
   output logic                  overflow_o,
   output logic                  valid_o
);

   localparam int N_BLOCKS = DATA_WIDTH / BLOCK_WIDTH;
   localparam int CNT_W    = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
   localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(N_BLOCKS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_COMPUTE, ST_DONE} state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic                   bin_q, bin_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]  result_q, result_d;
   logic                   borrow_q, borrow_d;
   logic                   overflow_q, overflow_d;

   logic [BLOCK_WIDTH-1:0] a_blk, b_blk, d_blk;
   logic                   rip_b, blk_bout, blk_eq;
   int                     blk_base;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         bin_q      <= 1'b0;
         cnt_q      <= '0;
         result_q   <= '0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         bin_q      <= bin_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         borrow_q   <= borrow_d;
         overflow_q <= overflow_d;
      end
   end

   // Slice datapath: ripple borrow, then skip mux on an all-equal slice.
   always_comb begin
      blk_base = int'(cnt_q) * BLOCK_WIDTH;
      a_blk    = BLOCK_WIDTH'(a_q >> blk_base);
      b_blk    = BLOCK_WIDTH'(b_q >> blk_base);
      d_blk    = '0;
      rip_b    = bin_q;
      for (int i = 0; i < BLOCK_WIDTH; i++) begin
         d_blk[i] = a_blk[i] ^ b_blk[i] ^ rip_b;
         rip_b    = (~a_blk[i] & b_blk[i]) | (~(a_blk[i] ^ b_blk[i]) & rip_b);
      end
      blk_eq   = &(~(a_blk ^ b_blk));
      blk_bout = blk_eq ? bin_q : rip_b;
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      bin_d      = bin_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      borrow_d   = borrow_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               a_d     = operand_A_i;
               b_d     = operand_B_i;
               bin_d   = borrow_i;
               cnt_d   = '0;
               state_d = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            result_d[blk_base +: BLOCK_WIDTH] = d_blk;
            bin_d = blk_bout;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BLK) begin
               cnt_d      = '0;
               borrow_d   = blk_bout;
               overflow_d = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &
                            (result_d[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
               state_d    = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign ready_o    = (state_q == ST_IDLE);
   assign valid_o    = (state_q == ST_DONE);
   assign result_o   = result_q;
   assign borrow_o   = borrow_q;
   assign overflow_o = overflow_q;

endmodule
